// File: rtl/gate_sweep_checker.sv
// Stimulus/response checker for a two-input and/or/xor/nand gate block.
// Walks the A/B inputs through a one-bit-change sweep, lets the gate settle and scores each vector.
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_a,
    output logic             in_b,
    input  logic             out_and,
    input  logic             out_or,
    input  logic             out_xor,
    input  logic             out_nand,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       err_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    state_t           state;
    logic [1:0]       vec_idx;
    logic [LW-1:0]    loop_cnt;
    logic [CW-1:0]    settle_cnt;
    logic [3:0]       expected;
    logic [3:0]       observed;
    logic [3:0]       mism;
    logic [ERR_W-1:0] err_next;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // Bit order matches err_vec: [3]nand [2]xor [1]or [0]and
    function automatic logic [3:0] truth(input logic a, input logic b);
        return {~(a & b), a ^ b, a | b, a & b};
    endfunction

    always_comb begin
        expected = truth(in_a, in_b);
        observed = {out_nand, out_xor, out_or, out_and};
        mism     = observed ^ expected;
        err_next = (|mism) ? sat_inc(err_count) : err_count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_a       <= 1'b0;
            in_b       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            err_vec    <= '0;
            vec_idx    <= '0;
            loop_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        err_vec    <= '0;
                        vec_idx    <= '0;
                        loop_cnt   <= '0;
                        settle_cnt <= '0;
                    end
                end
                DRIVE: begin
                    // Index 0..3 maps to {a,b} = 00,10,11,01 so only one input toggles per step
                    in_a       <= vec_idx[0] ^ vec_idx[1];
                    in_b       <= vec_idx[1];
                    settle_cnt <= '0;
                    state      <= (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    err_vec   <= err_vec | mism;
                    vec_idx   <= vec_idx + 2'd1;
                    if (vec_idx == 2'd3 && loop_cnt == LOOP_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        if (vec_idx == 2'd3) begin
                            loop_cnt <= loop_cnt + LW'(1);
                        end
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: three configurations, each driving its own behavioural gate.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_d, start_s, start_f;
    logic xor_stuck_d;
    logic inv_s;

    logic       d_a, d_b, d_and, d_or, d_xor, d_nand, d_busy, d_done, d_pass;
    logic [3:0] d_err, d_vec;
    logic       s_a, s_b, s_and, s_or, s_xor, s_nand, s_busy, s_done, s_pass;
    logic [1:0] s_err;
    logic [3:0] s_vec;
    logic       f_a, f_b, f_and, f_or, f_xor, f_nand, f_busy, f_done, f_pass;
    logic [3:0] f_err, f_vec;

    assign d_and  = d_a & d_b;
    assign d_or   = d_a | d_b;
    assign d_xor  = (d_a ^ d_b) & ~xor_stuck_d;
    assign d_nand = ~(d_a & d_b);

    assign s_and  = (s_a & s_b) ^ inv_s;
    assign s_or   = (s_a | s_b) ^ inv_s;
    assign s_xor  = (s_a ^ s_b) ^ inv_s;
    assign s_nand = ~(s_a & s_b) ^ inv_s;

    assign f_and  = f_a & f_b;
    assign f_or   = f_a | f_b;
    assign f_xor  = f_a ^ f_b;
    assign f_nand = ~(f_a & f_b);

    gate_sweep_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_d), .in_a(d_a), .in_b(d_b),
        .out_and(d_and), .out_or(d_or), .out_xor(d_xor), .out_nand(d_nand),
        .busy(d_busy), .done(d_done), .pass(d_pass), .err_count(d_err), .err_vec(d_vec)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .in_a(s_a), .in_b(s_b),
        .out_and(s_and), .out_or(s_or), .out_xor(s_xor), .out_nand(s_nand),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err), .err_vec(s_vec)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(4)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start_f), .in_a(f_a), .in_b(f_b),
        .out_and(f_and), .out_or(f_or), .out_xor(f_xor), .out_nand(f_nand),
        .busy(f_busy), .done(f_done), .pass(f_pass), .err_count(f_err), .err_vec(f_vec)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic busy_of(input int which);
        case (which)
            0:       return d_busy;
            1:       return s_busy;
            default: return f_busy;
        endcase
    endfunction

    // Counts samples with busy high, bounded so a stuck DUT still reaches the summary
    task automatic measure(input int which, output int n);
        n = 0;
        while (busy_of(which) && n < 200) begin
            n++;
            tick();
        end
    endtask

    int         n;
    logic [7:0] trace;

    initial begin
        rst_n = 1'b0;
        start_d = 1'b0; start_s = 1'b0; start_f = 1'b0;
        xor_stuck_d = 1'b0; inv_s = 1'b0;
        tick(); tick();
        check("rst_busy", d_busy, 0);
        check("rst_done", d_done, 0);
        check("rst_pass", d_pass, 0);
        check("rst_err",  d_err, 0);
        check("rst_vec",  d_vec, 0);
        check("rst_ab",   {d_a, d_b}, 0);
        check("rst_busy_s", s_busy, 0);
        check("rst_busy_f", f_busy, 0);
        rst_n = 1'b1;
        tick();
        check("idle_no_start", d_busy, 0);

        // Correct gate, single pulse
        start_d = 1'b1; tick(); start_d = 1'b0;
        check("t1_busy_rise", d_busy, 1);
        measure(0, n);
        check("t1_busy_len", n, 16);
        check("t1_done", d_done, 1);
        check("t1_pass", d_pass, 1);
        check("t1_err",  d_err, 0);
        check("t1_vec",  d_vec, 0);
        check("t1_ab_hold", {d_a, d_b}, 2'b01);

        // XOR output stuck at 0: vectors 10 and 01 fail
        xor_stuck_d = 1'b1;
        start_d = 1'b1; tick(); start_d = 1'b0;
        check("t2_done_clr", d_done, 0);
        measure(0, n);
        check("t2_busy_len", n, 16);
        check("t2_done", d_done, 1);
        check("t2_err",  d_err, 2);
        check("t2_vec",  d_vec, 4'b0100);
        check("t2_pass", d_pass, 0);

        // Restart from DONE after the failing run clears the results
        xor_stuck_d = 1'b0;
        start_d = 1'b1; tick(); start_d = 1'b0;
        check("t6_err_clr",  d_err, 0);
        check("t6_vec_clr",  d_vec, 0);
        check("t6_done_clr", d_done, 0);
        check("t6_busy",     d_busy, 1);
        measure(0, n);
        check("t6_busy_len", n, 16);
        check("t6_pass", d_pass, 1);

        // Start re-pulsed mid-run is ignored
        start_d = 1'b1; tick(); start_d = 1'b0;
        n = 0;
        while (d_busy && n < 200) begin
            start_d = (n == 5);
            n++;
            tick();
        end
        start_d = 1'b0;
        check("t4_busy_len", n, 16);
        check("t4_done", d_done, 1);

        // Reset mid-run abandons it
        start_d = 1'b1; tick(); start_d = 1'b0;
        repeat (6) tick();
        check("t4_ab_midrun", {d_a, d_b}, 2'b10);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("t4_rst_busy", d_busy, 0);
        check("t4_rst_done", d_done, 0);
        check("t4_rst_pass", d_pass, 0);
        check("t4_rst_err",  d_err, 0);
        check("t4_rst_vec",  d_vec, 0);
        check("t4_rst_ab",   {d_a, d_b}, 0);
        repeat (20) tick();
        check("t4_idle_busy", d_busy, 0);
        check("t4_idle_done", d_done, 0);

        // All outputs inverted, two loops, 2-bit saturating counter
        inv_s = 1'b1;
        start_s = 1'b1; tick(); start_s = 1'b0;
        measure(1, n);
        check("t3_busy_len", n, 32);
        check("t3_done", s_done, 1);
        check("t3_err_sat", s_err, 3);
        check("t3_vec", s_vec, 4'b1111);
        check("t3_pass", s_pass, 0);

        // Zero settle: two cycles per vector, input trace 00,10,11,01
        start_f = 1'b1; tick(); start_f = 1'b0;
        n = 0;
        trace = '0;
        while (f_busy && n < 200) begin
            if (n % 2 == 1 && n < 8) trace = {trace[5:0], f_a, f_b};
            n++;
            tick();
        end
        check("t5_busy_len", n, 8);
        check("t5_trace", trace, 8'b00_10_11_01);
        check("t5_pass", f_pass, 1);
        check("t5_err", f_err, 0);

        // Start held high restarts on reaching DONE
        start_f = 1'b1; tick();
        check("hold_busy", f_busy, 1);
        measure(2, n);
        check("hold_busy_len", n, 8);
        check("hold_done", f_done, 1);
        tick();
        check("hold_restart_busy", f_busy, 1);
        check("hold_restart_done", f_done, 0);
        start_f = 1'b0;
        measure(2, n);
        check("hold_final_pass", f_pass, 1);
        check("hold_final_vec", f_vec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
